// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_queue
// Purpose  : Instruction fetch queue between the PC/ROM fetch stage and ID.
//            Captures each fetched {pc, inst} pair into a circular buffer and
//            presents the oldest entry to ID with first-word fall-through
//            valid/ready. It raises stall_pc one entry early so that the
//            fetch already in flight through the 1-cycle ROM still fits.
//            flush discards all queued entries and the arriving fetch.
// Ports    : clk          - rising-edge clock
//            rst          - asynchronous reset, active-low
//            if_valid     - {if_pc, if_inst} fetch pair valid this cycle
//            if_pc        - pc of the fetched instruction
//            if_inst      - ROM read data for if_pc
//            flush        - discard all entries and the current fetch
//            stall_pc     - hold PC and ROM address
//            id_valid     - head entry valid
//            id_pc        - head entry pc
//            id_inst      - head entry instruction
//            id_ready     - ID consumes the head entry this cycle
//            count        - occupied entries, 0..DEPTH
//            overflow_err - sticky: a push was dropped because the queue was full
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [DATA_W-1:0]          if_inst,
    input  logic                       flush,
    output logic                       stall_pc,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [DATA_W-1:0]          id_inst,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_HIGH     = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf;
    logic [CNT_W-1:0]  w_count_next;

    assign w_full = (r_count == C_FULL);
    assign w_pop  = id_valid & id_ready & ~flush;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push = if_valid & ~flush & (~w_full | w_pop);
    assign w_ovf  = if_valid & ~flush & w_full & ~w_pop;

    assign w_count_next = r_count + {{(CNT_W-1){1'b0}}, w_push}
                                  - {{(CNT_W-1){1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_inst_mem[i] <= '0;
            end
        end else begin
            if (flush) begin
                // Storage is left as-is; zeroed pointers/count hide it.
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]   <= if_pc;
                    r_inst_mem[r_wr_ptr] <= if_inst;
                    r_wr_ptr             <= r_wr_ptr + C_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                end
                r_count <= w_count_next;
            end
            // Sticky until reset; flush does not clear it.
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Stall at DEPTH-1 leaves one slot for the fetch already issued to the ROM.
    assign stall_pc     = (r_count >= C_HIGH);
    assign id_valid     = (r_count != C_CNT_ZERO);
    assign id_pc        = r_pc_mem[r_rd_ptr];
    assign id_inst      = r_inst_mem[r_rd_ptr];
    assign count        = r_count;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_queue
// Purpose  : Self-checking bench for inst_fetch_queue (DEPTH=4) using a
//            queue-based reference model, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [DATA_W-1:0] if_inst;
    logic              flush;
    logic              stall_pc;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [DATA_W-1:0] id_inst;
    logic              id_ready;
    logic [2:0]        count;
    logic              overflow_err;

    int total;
    int bad;

    // Reference model: queue of {pc, inst}, plus the sticky overflow flag.
    logic [63:0] m_q[$];
    logic        m_ovf;

    logic [31:0] pc_seq;

    inst_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .flush        (flush),
        .stall_pc     (stall_pc),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_ready     (id_ready),
        .count        (count),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        int n;
        n = m_q.size();
        chk({where, ":count"},    64'(count),        64'(n));
        chk({where, ":id_valid"}, 64'(id_valid),     64'(n != 0));
        chk({where, ":stall_pc"}, 64'(stall_pc),     64'(n >= DEPTH - 1));
        chk({where, ":ovf"},      64'(overflow_err), 64'(m_ovf));
        if (n != 0) begin
            chk({where, ":id_pc"},   64'(id_pc),   64'(m_q[0][63:32]));
            chk({where, ":id_inst"}, 64'(id_inst), 64'(m_q[0][31:0]));
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, then advance
    // the model by the queue rules and move past the rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic rdy, input string where);
        logic pop;
        logic push;
        if_valid = v;
        if_pc    = pc;
        if_inst  = ins;
        flush    = fl;
        id_ready = rdy;
        @(negedge clk);
        check_outputs(where);
        pop  = (m_q.size() != 0) && rdy && !fl;
        push = v && !fl && ((m_q.size() < DEPTH) || pop);
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back({pc, ins});
            if (v && !push) m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5a5a_0f0f;
    endfunction

    task automatic push_next(input logic rdy, input string where);
        step(1'b1, pc_seq, inst_of(pc_seq), 1'b0, rdy, where);
        pc_seq = pc_seq + 32'd4;
    endtask

    task automatic drain(input string where);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, where);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        m_ovf    = 1'b0;
        rst      = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        flush    = 1'b0;
        id_ready = 1'b0;
        pc_seq   = 32'hbfc0_0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst:count",    64'(count),        64'd0);
        chk("rst:id_valid", 64'(id_valid),     64'd0);
        chk("rst:id_pc",    64'(id_pc),        64'd0);
        chk("rst:id_inst",  64'(id_inst),      64'd0);
        chk("rst:stall_pc", 64'(stall_pc),     64'd0);
        chk("rst:ovf",      64'(overflow_err), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1. Streaming with ID always ready
        for (int i = 0; i < 10; i++) push_next(1'b1, "stream");
        drain("stream_drain");

        // 2. Backpressure then drain in order
        pc_seq = 32'hbfc0_0000;
        for (int i = 0; i < 4; i++) push_next(1'b0, "bp_fill");
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "bp_drain");

        // 3. Full with simultaneous push/pop across pointer wrap
        for (int i = 0; i < 4; i++) push_next(1'b0, "full_fill");
        for (int i = 0; i < 6; i++) push_next(1'b1, "full_pushpop");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "full_hold");

        // 4. Overflow: pair dropped, flag sticky through flush
        push_next(1'b0, "ovf_push");
        push_next(1'b0, "ovf_push2");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ovf_after");
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "ovf_flush");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "ovf_post_flush");

        // 5. Flush at count=3 with push and pop in the same cycle
        for (int i = 0; i < 3; i++) push_next(1'b0, "fl_fill");
        step(1'b1, 32'hdead_beef, 32'h1234_5678, 1'b1, 1'b1, "fl_flush");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "fl_after");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "fl_after2");

        // 6. Asynchronous reset mid-operation at count=2
        for (int i = 0; i < 2; i++) push_next(1'b0, "ar_fill");
        if_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        chk("arst:id_valid", 64'(id_valid),     64'd0);
        chk("arst:count",    64'(count),        64'd0);
        chk("arst:stall_pc", 64'(stall_pc),     64'd0);
        chk("arst:ovf",      64'(overflow_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push_next(1'b0, "ar_push");
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "ar_first");
        drain("ar_drain");

        // Random traffic, mostly honouring the no-push-after-stall contract
        for (int i = 0; i < 400; i++) begin
            logic v;
            logic fl;
            logic rdy;
            v   = ($urandom_range(0, 99) < 65);
            if (stall_pc && ($urandom_range(0, 99) < 80)) v = 1'b0;
            fl  = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 50);
            step(v, pc_seq, $urandom, fl, rdy, "rand");
            if (v) pc_seq = pc_seq + 32'd4;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
